// File: rtl/adc_pkg.sv
// Shared types and widths for the MCP3202 sample controller.
package adc_pkg;

    localparam int ADC_BITS = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        BUSY    = 2'd2,
        CAPTURE = 2'd3
    } adc_state_t;

endpackage

// File: rtl/adc_sample_ctrl_if.sv
// SPI-side and DSP-side signals of the sample controller.
// Stream handshake: a word moves on any clk edge where sample_valid && sample_ready; sample_valid never depends on sample_ready.
interface adc_sample_ctrl_if;
    import adc_pkg::*;

    logic                sck;
    logic                start_read;
    logic                chip_en;
    logic [ADC_BITS-1:0] data_read;
    logic [ADC_BITS-1:0] sample;
    logic                sample_valid;
    logic                sample_ready;

    modport master (
        output sck, start_read, sample, sample_valid,
        input  chip_en, data_read, sample_ready
    );

    modport slave (
        input  sck, start_read, sample, sample_valid,
        output chip_en, data_read, sample_ready
    );

endinterface

// File: rtl/adc_sample_ctrl_sck_gen.sv
// Divides clk into the registered SPI clock; o_fall_tick marks the clk edge on which sck drops.
module adc_sample_ctrl_sck_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    output logic o_sck,
    output logic o_fall_tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] r_cnt;
    logic          r_sck;
    logic          w_wrap;

    assign w_wrap = i_enable && (r_cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (!i_enable) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // High during the cycle whose closing edge takes sck from 1 to 0.
    assign o_fall_tick = w_wrap & r_sck;
    assign o_sck       = r_sck;

endmodule

// File: rtl/adc_sample_ctrl.sv
// Sequences one MCP3202 read per sample period and holds the result in a valid/ready register.
module adc_sample_ctrl
    import adc_pkg::*;
#(
    parameter int CLK_DIV       = 8,
    parameter int SAMPLE_PERIOD = 2000,
    parameter int TIMEOUT_SCK   = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       clr_flags,
    output logic       overrun,
    output logic       timeout,
    output adc_state_t o_state,
    adc_sample_ctrl_if.master bus
);

    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int TW = $clog2(TIMEOUT_SCK + 1);

    adc_state_t          r_state;
    adc_state_t          w_next_state;
    logic                r_start_read;
    logic                w_next_start;
    logic [PW-1:0]       r_period;
    logic [TW-1:0]       r_to_cnt;
    logic                r_seen_cs;
    logic [ADC_BITS-1:0] r_sample;
    logic                r_valid;
    logic                r_overrun;
    logic                r_timeout;
    logic                w_sck;
    logic                w_fall;
    logic                w_tick;
    logic                w_capture;
    logic                w_to_hit;
    logic                w_ovr_set;

    adc_sample_ctrl_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk         (clk),
        .reset       (reset),
        .i_enable    (enable),
        .o_sck       (w_sck),
        .o_fall_tick (w_fall)
    );

    assign w_tick = enable && (r_period == PW'(SAMPLE_PERIOD - 1));

    always_comb begin
        w_next_state = r_state;
        w_next_start = r_start_read;
        w_capture    = 1'b0;
        w_to_hit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_tick) w_next_state = START;
            end
            // start_read rises on one sck fall and drops on the next.
            START: begin
                if (w_fall) begin
                    if (r_start_read) begin
                        w_next_start = 1'b0;
                        w_next_state = BUSY;
                    end else begin
                        w_next_start = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (bus.chip_en && r_seen_cs) begin
                    w_next_state = CAPTURE;
                end else if (w_fall && (r_to_cnt == TW'(TIMEOUT_SCK - 1))) begin
                    w_to_hit     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            CAPTURE: begin
                w_capture    = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
        if (!enable) begin
            w_next_state = IDLE;
            w_next_start = 1'b0;
            w_capture    = 1'b0;
            w_to_hit     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_start_read <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_start_read <= w_next_start;
        end
    end

    assign w_ovr_set = w_capture && r_valid && !bus.sample_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_period  <= '0;
            r_to_cnt  <= '0;
            r_seen_cs <= 1'b0;
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (!enable || w_tick) r_period <= '0;
            else                   r_period <= r_period + 1'b1;

            // chip_en comes from logic clocked by our own sck, so it is sampled without a synchronizer.
            if (enable && (r_state == BUSY)) begin
                r_seen_cs <= r_seen_cs | ~bus.chip_en;
                if (w_fall) r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_seen_cs <= 1'b0;
                r_to_cnt  <= '0;
            end

            if (w_capture) begin
                r_sample <= bus.data_read;
                r_valid  <= 1'b1;
            end else if (r_valid && bus.sample_ready) begin
                r_valid <= 1'b0;
            end

            if (w_ovr_set)      r_overrun <= 1'b1;
            else if (clr_flags) r_overrun <= 1'b0;

            if (w_to_hit)       r_timeout <= 1'b1;
            else if (clr_flags) r_timeout <= 1'b0;
        end
    end

    assign bus.sck          = w_sck;
    assign bus.start_read   = r_start_read;
    assign bus.sample       = r_sample;
    assign bus.sample_valid = r_valid;
    assign overrun          = r_overrun;
    assign timeout          = r_timeout;
    assign o_state          = r_state;

endmodule
